// File: rtl/sram_arbiter.sv
// sram_arbiter: fixed-priority (data over instruction) arbiter sharing one SRAM controller between two masters
//   clk, rstn          : clock, synchronous active-low reset
//   i_*  (instruction) : req/addr/w_rb/acc/wdata in; rdata/resp/fault out
//   d_*  (data)        : same as i_*; wins when both are pending
//   s_*  (controller)  : req/addr/w_rb/acc/wdata out; rdata/resp/fault in (s_fault valid in the s_req cycle)
`ifndef SRAM_VA_WIDTH
`define SRAM_VA_WIDTH 16
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module sram_arbiter #(
    parameter int AW   = `SRAM_VA_WIDTH,
    parameter int DW   = `BUS_WIDTH,
    parameter int ACCW = `BUS_ACC_WIDTH
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    input  logic            i_w_rb,
    input  logic [ACCW-1:0] i_acc,
    input  logic [DW-1:0]   i_wdata,
    output logic [DW-1:0]   i_rdata,
    output logic            i_resp,
    output logic            i_fault,
    input  logic            d_req,
    input  logic [AW-1:0]   d_addr,
    input  logic            d_w_rb,
    input  logic [ACCW-1:0] d_acc,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_resp,
    output logic            d_fault,
    output logic            s_req,
    output logic [AW-1:0]   s_addr,
    output logic            s_w_rb,
    output logic [ACCW-1:0] s_acc,
    output logic [DW-1:0]   s_wdata,
    input  logic [DW-1:0]   s_rdata,
    input  logic            s_resp,
    input  logic            s_fault
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state_q, state_d;
    logic            own_q, own_d;
    logic            i_v_q, i_v_d, d_v_q, d_v_d;
    logic [AW-1:0]   i_addr_q, d_addr_q;
    logic            i_w_rb_q, d_w_rb_q;
    logic [ACCW-1:0] i_acc_q, d_acc_q;
    logic [DW-1:0]   i_wdata_q, d_wdata_q;
    logic            done, i_busy, d_busy, i_load, d_load;

    // A transaction ends on a fault in ISSUE or a response in WAIT; the owner may queue its next request in that cycle.
    assign done   = (state_q == ISSUE && s_fault) || (state_q == WAIT && s_resp);
    assign i_busy = state_q != IDLE && !own_q;
    assign d_busy = state_q != IDLE && own_q;
    assign i_load = rstn && i_req && (i_busy ? done : !i_v_q);
    assign d_load = rstn && d_req && (d_busy ? done : !d_v_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            own_q   <= 1'b0;
            i_v_q   <= 1'b0;
            d_v_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            i_v_q   <= i_v_d;
            d_v_q   <= d_v_d;
        end
    end

    // Payload is qualified by the valid bits, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (i_load) begin
            i_addr_q  <= i_addr;
            i_w_rb_q  <= i_w_rb;
            i_acc_q   <= i_acc;
            i_wdata_q <= i_wdata;
        end
        if (d_load) begin
            d_addr_q  <= d_addr;
            d_w_rb_q  <= d_w_rb;
            d_acc_q   <= d_acc;
            d_wdata_q <= d_wdata;
        end
    end

    // Master-facing pulses are gated by rstn so a reset cycle never completes a transaction.
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        i_v_d   = i_v_q;
        d_v_d   = d_v_q;
        s_req   = 1'b0;
        i_resp  = 1'b0;
        d_resp  = 1'b0;
        i_fault = 1'b0;
        d_fault = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_v_q || d_v_q) begin
                    state_d = ISSUE;
                    own_d   = d_v_q;
                end
            end
            ISSUE: begin
                s_req   = rstn;
                i_v_d   = own_q ? i_v_q : 1'b0;
                d_v_d   = own_q ? 1'b0 : d_v_q;
                i_fault = rstn && !own_q && s_fault;
                d_fault = rstn && own_q && s_fault;
                state_d = s_fault ? IDLE : WAIT;
            end
            WAIT: begin
                i_resp  = rstn && !own_q && s_resp;
                d_resp  = rstn && own_q && s_resp;
                state_d = s_resp ? IDLE : WAIT;
            end
            default: state_d = IDLE;
        endcase
        if (i_load) i_v_d = 1'b1;
        if (d_load) d_v_d = 1'b1;
    end

    // The owner's buffer cannot be reloaded before its transaction ends, so these stay stable through WAIT.
    assign s_addr  = own_q ? d_addr_q : i_addr_q;
    assign s_w_rb  = own_q ? d_w_rb_q : i_w_rb_q;
    assign s_acc   = own_q ? d_acc_q : i_acc_q;
    assign s_wdata = own_q ? d_wdata_q : i_wdata_q;
    assign i_rdata = i_resp ? s_rdata : '0;
    assign d_rdata = d_resp ? s_rdata : '0;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized scoreboard bench for sram_arbiter with a rule-level reference model
module tb_sram_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int ACCW = 2;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic            w_rb;
        logic [ACCW-1:0] acc;
        logic [DW-1:0]   wdata;
    } req_t;
    typedef struct {
        int   cyc;
        req_t r;
    } sexp_t;
    typedef struct {
        int            cyc;
        logic          fault;
        logic [DW-1:0] rdata;
    } mexp_t;

    logic            clk = 0, rstn = 0;
    logic            i_req = 0, d_req = 0;
    logic [AW-1:0]   i_addr = 0, d_addr = 0;
    logic            i_w_rb = 0, d_w_rb = 0;
    logic [ACCW-1:0] i_acc = 0, d_acc = 0;
    logic [DW-1:0]   i_wdata = 0, d_wdata = 0;
    logic [DW-1:0]   i_rdata, d_rdata;
    logic            i_resp, d_resp, i_fault, d_fault;
    logic            s_req, s_w_rb, s_fault;
    logic [AW-1:0]   s_addr;
    logic [ACCW-1:0] s_acc;
    logic [DW-1:0]   s_wdata;
    logic [DW-1:0]   s_rdata = 0;
    logic            s_resp = 0, noise_fault = 0;

    int checks = 0, errors = 0, cyc = 0;

    sram_arbiter #(.AW(AW), .DW(DW), .ACCW(ACCW)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_w_rb(i_w_rb), .i_acc(i_acc), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_resp(i_resp), .i_fault(i_fault),
        .d_req(d_req), .d_addr(d_addr), .d_w_rb(d_w_rb), .d_acc(d_acc), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp), .d_fault(d_fault),
        .s_req(s_req), .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_resp(s_resp), .s_fault(s_fault)
    );

    always #5 clk = ~clk;

    // Controller rejects misaligned accesses: 2B on odd address, 4B not word aligned.
    function automatic logic mis(input logic [AW-1:0] a, input logic [ACCW-1:0] ac);
        return (ac == 2'd1 && a[0]) || (ac == 2'd2 && a[1:0] != 2'b00);
    endfunction

    assign s_fault = s_req ? mis(s_addr, s_acc) : noise_fault;

    function automatic req_t rnd(input bit al);
        req_t r;
        r.addr = AW'($urandom);
        if (al) r.addr[1:0] = 2'b00;
        r.w_rb = 1'($urandom);
        r.acc = ACCW'($urandom_range(0, 2));
        r.wdata = $urandom;
        return r;
    endfunction

    // Controller stimulus state
    int            cnt = 0, force_lat = 0;
    bit            noise = 0, force_en = 0;
    logic [DW-1:0] force_data = 0, cur_data = 0;
    req_t          ni, nd;

    // Reference model: one outstanding request per master, data before instruction,
    // a decision cycle between transactions, owner freed in its completion cycle.
    sexp_t exp_s[$];
    mexp_t exp_i[$], exp_d[$];
    req_t  pend[2], tx, hold;
    logic  pv[2], occ[2];
    logic  act = 0, hold_v = 0;
    int    am = 0, issue = 0;

    initial begin
        pv[0] = 0; pv[1] = 0; occ[0] = 0; occ[1] = 0;
    end

    task automatic finish_txn(input logic f, input logic [DW-1:0] rd);
        mexp_t e;
        e.cyc = cyc;
        e.fault = f;
        e.rdata = f ? '0 : rd;
        if (am == 1) exp_d.push_back(e);
        else exp_i.push_back(e);
        act = 0;
        occ[am] = 0;
    endtask

    task automatic model();
        sexp_t se;
        hold_v = 0;
        if (!rstn) begin
            pv[0] = 0; pv[1] = 0; occ[0] = 0; occ[1] = 0;
            act = 0;
            return;
        end
        if (!act && (pv[0] || pv[1])) begin
            am = pv[1] ? 1 : 0;
            act = 1;
            issue = cyc + 1;
            tx = pend[am];
            pv[am] = 0;
        end
        if (act && cyc == issue) begin
            se.cyc = cyc;
            se.r = tx;
            exp_s.push_back(se);
            if (mis(tx.addr, tx.acc)) finish_txn(1'b1, '0);
        end else if (act && cyc > issue) begin
            hold_v = 1;
            hold = tx;
            if (s_resp) finish_txn(1'b0, s_rdata);
        end
        if (i_req && !occ[0]) begin
            pend[0] = {i_addr, i_w_rb, i_acc, i_wdata};
            pv[0] = 1;
            occ[0] = 1;
        end
        if (d_req && !occ[1]) begin
            pend[1] = {d_addr, d_w_rb, d_acc, d_wdata};
            pv[1] = 1;
            occ[1] = 1;
        end
    endtask

    task automatic step(input logic ir, input logic dr, input logic rs);
        @(negedge clk);
        cyc++;
        rstn = rs;
        i_req = ir;
        d_req = dr;
        {i_addr, i_w_rb, i_acc, i_wdata} = ni;
        {d_addr, d_w_rb, d_acc, d_wdata} = nd;
        s_resp = 0;
        s_rdata = $urandom;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                s_resp = 1;
                s_rdata = cur_data;
            end
        end else begin
            s_resp = noise && ($urandom_range(0, 15) == 0);
        end
        noise_fault = noise && ($urandom_range(0, 7) == 0);
        #1;
        if (s_req === 1'b1 && s_fault === 1'b0) begin
            cnt = force_lat != 0 ? force_lat : $urandom_range(1, 5);
            cur_data = force_en ? force_data : $urandom;
        end
        model();
    endtask

    task automatic check_m(input int m, input logic rsp, input logic flt, input logic [DW-1:0] rd);
        mexp_t e;
        logic hit, er, ef;
        logic [DW-1:0] ed;
        hit = 0; er = 0; ef = 0; ed = '0;
        if (m == 0 && exp_i.size() > 0 && exp_i[0].cyc <= cyc) begin e = exp_i.pop_front(); hit = 1; end
        if (m == 1 && exp_d.size() > 0 && exp_d[0].cyc <= cyc) begin e = exp_d.pop_front(); hit = 1; end
        if (hit) begin
            er = !e.fault;
            ef = e.fault;
            ed = e.rdata;
        end
        checks++;
        if (rsp !== er || flt !== ef || rd !== ed) begin
            errors++;
            $display("FAIL %s_out cyc %0d: got resp=%b fault=%b rdata=%h, want resp=%b fault=%b rdata=%h",
                     m == 1 ? "d" : "i", cyc, rsp, flt, rd, er, ef, ed);
        end
    endtask

    // Monitor: compares every cycle against whatever the model queued for that cycle.
    always @(negedge clk) begin
        sexp_t e;
        #2;
        if (cyc > 0) begin
            checks++;
            if (exp_s.size() > 0 && exp_s[0].cyc <= cyc) begin
                e = exp_s.pop_front();
                if (s_req !== 1'b1 || {s_addr, s_w_rb, s_acc, s_wdata} !== e.r) begin
                    errors++;
                    $display("FAIL s_issue cyc %0d: got req=%b addr=%h w_rb=%b acc=%0d wdata=%h, want req=1 addr=%h w_rb=%b acc=%0d wdata=%h",
                             cyc, s_req, s_addr, s_w_rb, s_acc, s_wdata, e.r.addr, e.r.w_rb, e.r.acc, e.r.wdata);
                end
            end else if (s_req !== 1'b0) begin
                errors++;
                $display("FAIL s_idle cyc %0d: got s_req=%b, want 0", cyc, s_req);
            end
            if (hold_v) begin
                checks++;
                if ({s_addr, s_w_rb, s_acc, s_wdata} !== hold) begin
                    errors++;
                    $display("FAIL s_hold cyc %0d: got addr=%h wdata=%h, want addr=%h wdata=%h",
                             cyc, s_addr, s_wdata, hold.addr, hold.wdata);
                end
            end
            check_m(0, i_resp, i_fault, i_rdata);
            check_m(1, d_resp, d_fault, d_rdata);
        end
    end

    initial begin
        ni = rnd(1'b1);
        nd = rnd(1'b1);
        repeat (3) step(0, 0, 0);
        step(0, 0, 1);
        // Single aligned data read, controller answers 4 cycles after s_req
        nd = '{addr: 16'h0010, w_rb: 1'b0, acc: 2'd2, wdata: 32'h0};
        force_lat = 4;
        force_en = 1;
        force_data = 32'hA5A5_1234;
        step(0, 1, 1);
        repeat (8) step(0, 0, 1);
        force_en = 0;
        force_lat = 0;
        // Simultaneous requests: data first, instruction right after
        ni = rnd(1'b1);
        nd = rnd(1'b1);
        step(1, 1, 1);
        repeat (16) step(0, 0, 1);
        // Misaligned 2B data access faults in ISSUE
        nd = '{addr: 16'h0001, w_rb: 1'b1, acc: 2'd1, wdata: 32'hDEAD_BEEF};
        step(0, 1, 1);
        repeat (4) step(0, 0, 1);
        // Instruction request during data WAIT, then redundant instruction requests ignored
        force_lat = 5;
        nd = rnd(1'b1);
        step(0, 1, 1);
        repeat (2) step(0, 0, 1);
        ni = rnd(1'b1);
        step(1, 0, 1);
        step(0, 0, 1);
        ni = rnd(1'b1);
        step(1, 0, 1);
        repeat (4) step(0, 0, 1);
        ni = rnd(1'b1);
        step(1, 0, 1);
        repeat (10) step(0, 0, 1);
        // Reset during WAIT; stale controller response arrives afterwards, request in reset dropped
        nd = rnd(1'b1);
        step(0, 1, 1);
        repeat (3) step(0, 0, 1);
        ni = rnd(1'b1);
        step(1, 0, 0);
        repeat (10) step(0, 0, 1);
        // Randomized traffic with spurious controller pulses and rare resets
        force_lat = 0;
        noise = 1;
        repeat (400) begin
            ni = rnd(1'b0);
            nd = rnd(1'b0);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 199) != 0);
        end
        noise = 0;
        repeat (20) step(0, 0, 1);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
